// File: rtl/frame_arb_pkg.sv
// Shared types and constants for the frame capture arbiter: FSM states,
// error codes and the beat-counter width helper.
package frame_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STREAM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_SPUR    = 2'd3;

  // Room for RAM_DEEP+1 so an overlong frame is detectable on the extra beat.
  function automatic int beat_cnt_w(input int ram_deep);
    return $clog2(ram_deep + 2);
  endfunction

endpackage

// File: rtl/frame_capture_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int         jj;
  logic [IDX_W-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    jj  = 0;
    j   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      jj = (int'(ptr) + i) % NUM_REQ;
      j  = IDX_W'(jj);
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_capture_arbiter.sv
// Shares one frame capture buffer among NUM_REQ consumers: round-robin grant,
// held capture request, read-out beat tracking, timeout and length checking.
module frame_capture_arbiter
  import frame_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int RAM_DEEP = 2048,
  parameter int REQ_HOLD = 16,
  parameter int TIMEOUT  = 65535
) (
  input  logic               rd_clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic               err_o,
  output logic [1:0]         err_code_o,
  output logic               fifo_request,
  input  logic               fifo_data_vaild,
  input  logic               fifo_data_tlast,
  output logic               busy_o,
  output logic [15:0]        frame_cnt_o
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = beat_cnt_w(RAM_DEEP);
  localparam int HOLD_W = $clog2(REQ_HOLD + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RAM_DEEP);
  localparam logic [BEAT_W-1:0] BEAT_OVER = BEAT_W'(RAM_DEEP + 1);
  localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(REQ_HOLD);
  localparam logic [TMR_W-1:0]  TMR_END   = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, ptr_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, beat_nx;
  logic [1:0]          code_d, err_code_q;
  logic                err_q, spur;
  logic [15:0]         frame_cnt_q;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Stream activity outside a capture window is flagged, never counted.
  assign spur = ((state_q == S_IDLE) || (state_q == S_ISSUE)) &&
                (fifo_data_vaild || fifo_data_tlast);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tmr_d   = tmr_q;
    beat_d  = beat_q;
    beat_nx = beat_q + 1'b1;
    code_d  = ERR_NONE;
    case (state_q)
      S_IDLE: if (arb_any) begin
        state_d = S_ISSUE;
        hold_d  = HOLD_W'(1);
      end
      S_ISSUE: if (hold_q == HOLD_END) begin
        state_d = S_WAIT;
        tmr_d   = '0;
      end else begin
        hold_d = hold_q + 1'b1;
      end
      S_WAIT: if (fifo_data_vaild) begin
        beat_d = BEAT_ONE;
        tmr_d  = '0;
        if (!fifo_data_tlast)       state_d = S_STREAM;
        else if (BEAT_ONE == BEAT_LAST) state_d = S_DONE;
        else begin state_d = S_ERR; code_d = ERR_LEN; end
      end else if (tmr_q == TMR_END) begin
        state_d = S_ERR;
        code_d  = ERR_TIMEOUT;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      S_STREAM: if (fifo_data_vaild) begin
        beat_d = beat_nx;
        tmr_d  = '0;
        if (fifo_data_tlast) begin
          if (beat_nx == BEAT_LAST) state_d = S_DONE;
          else begin state_d = S_ERR; code_d = ERR_LEN; end
        end else if (beat_nx == BEAT_OVER) begin
          state_d = S_ERR;
          code_d  = ERR_LEN;
        end
      end else if (tmr_q == TMR_END) begin
        state_d = S_ERR;
        code_d  = ERR_TIMEOUT;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      hold_q      <= '0;
      tmr_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tmr_q   <= tmr_d;
      beat_q  <= beat_d;
      if ((state_q == S_IDLE) && arb_any) begin
        idx_q <= arb_idx;
        gnt_q <= arb_gnt;
      end
      // Winner drops to lowest priority once its transaction ends either way.
      if ((state_q == S_DONE) || (state_q == S_ERR))
        ptr_q <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      if (state_q == S_DONE)
        frame_cnt_q <= frame_cnt_q + 16'd1;
      err_q <= (state_d == S_ERR) || spur;
      if (state_d == S_ERR)
        err_code_q <= code_d;
      else if (spur)
        err_code_q <= ERR_SPUR;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign grant_o      = busy_o ? gnt_q : '0;
  assign done_o       = (state_q == S_DONE) ? gnt_q : '0;
  assign fifo_request = (state_q == S_ISSUE);
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_frame_capture_arbiter.sv
// Directed bench for frame_capture_arbiter with a small buffer configuration.
module tb_frame_capture_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_i;
  logic [3:0]  grant_o;
  logic [3:0]  done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        fifo_request;
  logic        fifo_data_vaild;
  logic        fifo_data_tlast;
  logic        busy_o;
  logic [15:0] frame_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  frame_capture_arbiter #(
    .NUM_REQ(4), .RAM_DEEP(8), .REQ_HOLD(4), .TIMEOUT(32)
  ) dut (
    .rd_clk          (clk),
    .rst_n           (rst_n),
    .req_i           (req_i),
    .grant_o         (grant_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .err_code_o      (err_code_o),
    .fifo_request    (fifo_request),
    .fifo_data_vaild (fifo_data_vaild),
    .fifo_data_tlast (fifo_data_tlast),
    .busy_o          (busy_o),
    .frame_cnt_o     (frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0; req_i = '0; fifo_data_vaild = 1'b0; fifo_data_tlast = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Observe the issue phase: grant seen with first fifo_request, latency and hold length.
  task automatic run_issue(output logic [3:0] g, output int lat, output int hold);
    g = '0; lat = 0; hold = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (fifo_request) begin
        if (hold == 0) begin g = grant_o; lat = c; end
        hold++;
      end else if (hold > 0) begin
        break;
      end
    end
  endtask

  // Buffer model: n valid beats, tlast on beat last_at, gap idle cycles between beats.
  task automatic send_beats(input int n, input int last_at, input int gap);
    for (int b = 1; b <= n; b++) begin
      fifo_data_vaild = 1'b1;
      fifo_data_tlast = (b == last_at);
      @(negedge clk);
      fifo_data_vaild = 1'b0;
      fifo_data_tlast = 1'b0;
      if (b < n) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = 4'b1111; fifo_data_vaild = 1'b0; fifo_data_tlast = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({grant_o, done_o, err_o, err_code_o, fifo_request, busy_o} !== 13'd0) begin n_err++; $display("FAIL reset_outputs: got %b want 0", {grant_o, done_o, err_o, err_code_o, fifo_request, busy_o}); end
    n_cmp++; if (frame_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt_o); end
    req_i = '0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_single();
    logic [3:0] g; int lat, hold;
    apply_reset();
    req_i = 4'b0001;
    run_issue(g, lat, hold);
    req_i = 4'b0000;
    n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", g); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL single_latency: got %0d want 1", lat); end
    n_cmp++; if (hold !== 4) begin n_err++; $display("FAIL single_req_hold: got %0d want 4", hold); end
    n_cmp++; if (grant_o !== 4'b0001) begin n_err++; $display("FAIL single_grant_wait: got %b want 0001", grant_o); end
    send_beats(8, 8, 2);
    n_cmp++; if (done_o !== 4'b0001) begin n_err++; $display("FAIL single_done: got %b want 0001", done_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL single_no_err: got %b want 0", err_o); end
    @(negedge clk);
    n_cmp++; if (done_o !== 4'b0000) begin n_err++; $display("FAIL single_done_pulse: got %b want 0000", done_o); end
    n_cmp++; if (grant_o !== 4'b0000) begin n_err++; $display("FAIL single_release: got %b want 0000", grant_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", busy_o); end
    n_cmp++; if (frame_cnt_o !== 16'd1) begin n_err++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0] g, exp_g; int lat, hold;
    apply_reset();
    req_i = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp_g = 4'b0001 << (f % 4);
      run_issue(g, lat, hold);
      n_cmp++; if (g !== exp_g) begin n_err++; $display("FAIL rr_grant_%0d: got %b want %b", f, g, exp_g); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rr_latency_%0d: got %0d want 1", f, lat); end
      send_beats(8, 8, 0);
      n_cmp++; if (done_o !== exp_g) begin n_err++; $display("FAIL rr_done_%0d: got %b want %b", f, done_o, exp_g); end
      @(negedge clk);
      n_cmp++; if (frame_cnt_o !== 16'(f + 1)) begin n_err++; $display("FAIL rr_frame_cnt_%0d: got %0d want %0d", f, frame_cnt_o, f + 1); end
    end
    req_i = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [3:0] g; int lat, hold, n;
    apply_reset();
    req_i = 4'b0010;
    run_issue(g, lat, hold);
    req_i = 4'b0000;
    n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL to_grant: got %b want 0010", g); end
    n = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      n = c;
      if (err_o) break;
    end
    n_cmp++; if (n !== 32) begin n_err++; $display("FAIL to_cycles: got %0d want 32", n); end
    n_cmp++; if (err_code_o !== 2'd1) begin n_err++; $display("FAIL to_code: got %0d want 1", err_code_o); end
    n_cmp++; if (done_o !== 4'b0000) begin n_err++; $display("FAIL to_no_done: got %b want 0000", done_o); end
    @(negedge clk);
    n_cmp++; if ({grant_o, busy_o, err_o} !== 6'd0) begin n_err++; $display("FAIL to_release: got %b want 0", {grant_o, busy_o, err_o}); end
    n_cmp++; if (err_code_o !== 2'd1) begin n_err++; $display("FAIL to_code_held: got %0d want 1", err_code_o); end
    n_cmp++; if (frame_cnt_o !== 16'd0) begin n_err++; $display("FAIL to_frame_cnt: got %0d want 0", frame_cnt_o); end
  endtask

  task automatic test_length();
    logic [3:0] g; int lat, hold;
    apply_reset();
    req_i = 4'b0100;
    run_issue(g, lat, hold);
    n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL len_short_grant: got %b want 0100", g); end
    send_beats(6, 6, 0);
    n_cmp++; if (err_o !== 1'b1 || err_code_o !== 2'd2) begin n_err++; $display("FAIL len_short: got err=%b code=%0d want err=1 code=2", err_o, err_code_o); end
    n_cmp++; if (done_o !== 4'b0000) begin n_err++; $display("FAIL len_short_no_done: got %b want 0000", done_o); end
    @(negedge clk);
    n_cmp++; if (grant_o !== 4'b0000) begin n_err++; $display("FAIL len_short_release: got %b want 0000", grant_o); end
    run_issue(g, lat, hold);
    req_i = 4'b0000;
    n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL len_long_grant: got %b want 0100", g); end
    send_beats(8, 0, 0);
    n_cmp++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin n_err++; $display("FAIL len_long_beat8: got err=%b busy=%b want err=0 busy=1", err_o, busy_o); end
    send_beats(1, 0, 0);
    n_cmp++; if (err_o !== 1'b1 || err_code_o !== 2'd2) begin n_err++; $display("FAIL len_long_beat9: got err=%b code=%0d want err=1 code=2", err_o, err_code_o); end
    @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0 || frame_cnt_o !== 16'd0) begin n_err++; $display("FAIL len_long_end: got busy=%b cnt=%0d want busy=0 cnt=0", busy_o, frame_cnt_o); end
  endtask

  task automatic test_spurious();
    apply_reset();
    fifo_data_vaild = 1'b1;
    @(negedge clk);
    fifo_data_vaild = 1'b0;
    n_cmp++; if (err_o !== 1'b1 || err_code_o !== 2'd3) begin n_err++; $display("FAIL spur_err: got err=%b code=%0d want err=1 code=3", err_o, err_code_o); end
    n_cmp++; if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin n_err++; $display("FAIL spur_idle: got busy=%b grant=%b want 0 0000", busy_o, grant_o); end
    @(negedge clk);
    n_cmp++; if (err_o !== 1'b0 || err_code_o !== 2'd3) begin n_err++; $display("FAIL spur_pulse: got err=%b code=%0d want err=0 code=3", err_o, err_code_o); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] g; int lat, hold;
    apply_reset();
    req_i = 4'b0001;
    run_issue(g, lat, hold);
    req_i = 4'b0000;
    send_beats(8, 8, 0);
    @(negedge clk);
    req_i = 4'b0100;
    run_issue(g, lat, hold);
    req_i = 4'b0000;
    n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL mid_grant: got %b want 0100", g); end
    send_beats(4, 0, 0);
    fifo_data_vaild = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({fifo_request, grant_o, busy_o} !== 6'd0) begin n_err++; $display("FAIL mid_async_drop: got %b want 0", {fifo_request, grant_o, busy_o}); end
    fifo_data_vaild = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (frame_cnt_o !== 16'd0 || err_o !== 1'b0) begin n_err++; $display("FAIL mid_after_reset: got cnt=%0d err=%b want 0 0", frame_cnt_o, err_o); end
    req_i = 4'b1001;
    run_issue(g, lat, hold);
    req_i = 4'b0000;
    n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL mid_ptr_restart: got %b want 0001", g); end
    send_beats(8, 8, 0);
    n_cmp++; if (done_o !== 4'b0001) begin n_err++; $display("FAIL mid_done: got %b want 0001", done_o); end
    @(negedge clk);
    n_cmp++; if (frame_cnt_o !== 16'd1) begin n_err++; $display("FAIL mid_frame_cnt: got %0d want 1", frame_cnt_o); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_length();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
